// File: rtl/im_loader_if.sv
// im_loader bus bundle: fetch port and byte-serial load port.
// master = fetch stage / host loader, slave = the memory block.
interface im_loader_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
);
  localparam int AW = $clog2(DEPTH);

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  logic              load_start;
  logic [AW-1:0]     load_base;
  logic              load_byte_valid;
  logic [7:0]        load_byte;
  logic              load_end;
  logic              load_busy;
  logic              load_done;
  logic              load_ovf;
  logic [AW:0]       load_count;

  modport master (
    output fetch_req, fetch_addr,
    input  fetch_ready, fetch_valid, fetch_data, fetch_err,
    output load_start, load_base, load_byte_valid, load_byte, load_end,
    input  load_busy, load_done, load_ovf, load_count
  );

  modport slave (
    input  fetch_req, fetch_addr,
    output fetch_ready, fetch_valid, fetch_data, fetch_err,
    input  load_start, load_base, load_byte_valid, load_byte, load_end,
    output load_busy, load_done, load_ovf, load_count
  );
endinterface

// File: rtl/im_loader.sv
// im_loader: instruction memory with 1-cycle handshaked fetch
// and a byte-serial run-time program load port.
module im_loader #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  im_loader_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;
  localparam int BS = $clog2(NB);
  localparam int LW = (BS > 0) ? BS : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [AW:0]       ptr_q, ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              fv_q, fv_d;
  logic [DATA_W-1:0] fd_q, fd_d;
  logic              fe_q, fe_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] asm_b;
  logic              full;

  logic              ready;
  logic              acc;
  logic              err;
  logic [AW-1:0]     idx;

  // load FSM: byte assembly, word writes, exhaustion tracking
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    asm_d   = asm_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    waddr   = ptr_q[AW-1:0];
    wdata   = asm_q;
    full    = ptr_q[AW];
    asm_b   = asm_q | (DATA_W'(bus.load_byte) << (8 * lane_q));
    unique case (state_q)
      S_IDLE: begin
        if (bus.load_start) begin
          state_d = S_LOAD;
          lane_d  = '0;
          asm_d   = '0;
          ptr_d   = {1'b0, bus.load_base};
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (bus.load_byte_valid) begin
          if (full) begin
            ovf_d = 1'b1;
          end else if (lane_q == LW'(NB - 1)) begin
            we     = 1'b1;
            wdata  = asm_b;
            ptr_d  = ptr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            lane_d = '0;
            asm_d  = '0;
          end else begin
            lane_d = lane_q + 1'b1;
            asm_d  = asm_b;
          end
        end
        if (bus.load_end) begin
          // a partial word never coincides with a full-word write
          if (lane_d != '0) begin
            we     = 1'b1;
            wdata  = asm_d;
            cnt_d  = cnt_q + 1'b1;
            lane_d = '0;
            asm_d  = '0;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // fetch path: decode, range check, registered response
  always_comb begin
    ready = (state_q == S_IDLE);
    acc   = bus.fetch_req & ready;
    err   = (|(bus.fetch_addr & ADDR_W'(NB - 1)))
          | (|(bus.fetch_addr >> (BS + AW)));
    idx   = bus.fetch_addr[BS+AW-1:BS];
    fv_d  = acc;
    fd_d  = fd_q;
    fe_d  = fe_q;
    if (acc) begin
      fe_d = err;
      fd_d = err ? '0 : mem[idx];
    end
  end

  // control and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      asm_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fv_q    <= 1'b0;
      fd_q    <= '0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fv_q    <= fv_d;
      fd_q    <= fd_d;
      fe_q    <= fe_d;
    end
  end

  // storage array: not reset so programs survive rst
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign bus.fetch_ready = ready;
  assign bus.fetch_valid = fv_q;
  assign bus.fetch_data  = fd_q;
  assign bus.fetch_err   = fe_q;
  assign bus.load_busy   = (state_q != S_IDLE);
  assign bus.load_done   = (state_q == S_DONE);
  assign bus.load_ovf    = ovf_q;
  assign bus.load_count  = cnt_q;
endmodule
